isp_uart_host: RTL and testbench

ISP_UART_HOST -- requirements
Module: isp_uart_host

---
 rtl/isp_uart_host_pkg.sv | 85 ++++++++
 rtl/isp_host_byte_tx.sv | 61 ++++++
 rtl/isp_uart_host.sv | 197 +++++++++++++++++++
 tb/tb_isp_uart_host.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_uart_host_pkg.sv
// Shared types, protocol strings and ASCII helpers for the ISP UART host.
// Multi-byte strings are packed with the first byte on the wire in the MSBs.
package isp_uart_host_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RESET = 2'd2,
        OP_OPEN  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_INVALID = 2'd1,
        ST_TIMEOUT = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC_TX = 3'd1,
        S_SYNC_RX = 3'd2,
        S_CMD_TX  = 3'd3,
        S_RSP_RX  = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [7:0]  CH_LF        = 8'h0a;
    localparam logic [7:0]  CH_SP        = 8'h20;
    localparam logic [7:0]  CH_R         = 8'h72;
    localparam logic [7:0]  CH_O         = 8'h6f;
    localparam logic [63:0] STR_DEBUG    = 64'h0d0a_6465_6275_6720;
    localparam logic [63:0] STR_WR_DONE  = 64'h7772_2064_6f6e_6520;
    localparam logic [63:0] STR_RST_DONE = 64'h7273_7420_646f_6e65;
    localparam logic [63:0] STR_USER     = 64'h7573_6572_2020_2020;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

    // k selects the nibble counting from the most significant one
    function automatic logic [3:0] nib(input logic [31:0] v, input logic [4:0] k);
        logic [31:0] s;
        s = v >> (5'd28 - {k[2:0], 2'b00});
        return s[3:0];
    endfunction

    function automatic logic [4:0] cmd_len(input op_e op);
        case (op)
            OP_READ:  return 5'd9;
            OP_WRITE: return 5'd18;
            OP_RESET: return 5'd10;
            OP_OPEN:  return 5'd2;
            default:  return 5'd2;
        endcase
    endfunction

    function automatic logic [7:0] cmd_byte(input op_e op, input logic [31:0] addr,
                                            input logic [31:0] data, input logic [4:0] idx);
        case (op)
            OP_READ:  return (idx < 5'd8) ? hex_char(nib(addr, idx)) : CH_LF;
            OP_WRITE: begin
                if (idx < 5'd8)       return hex_char(nib(addr, idx));
                else if (idx == 5'd8) return CH_SP;
                else if (idx < 5'd17) return hex_char(nib(data, idx - 5'd9));
                else                  return CH_LF;
            end
            OP_RESET: begin
                if (idx == 5'd0)      return CH_R;
                else if (idx < 5'd9)  return hex_char(nib(data, idx - 5'd1));
                else                  return CH_LF;
            end
            OP_OPEN:  return (idx == 5'd0) ? CH_O : CH_LF;
            default:  return CH_LF;
        endcase
    endfunction

endpackage

// File: rtl/isp_host_byte_tx.sv
// 8N1 serializer: start, 8 data bits LSB first, stop; each bit CLK_DIV cycles.
module isp_host_byte_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    logic [8:0]  shift_r;
    logic [3:0]  bit_r;
    logic [31:0] div_r;
    logic        busy_r;
    logic        done_r;
    logic        tx_r;

    // bit timing, shifting and the one-cycle done pulse after the stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 9'h1ff;
            bit_r   <= 4'd0;
            div_r   <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            tx_r    <= 1'b1;
        end else begin
            done_r <= 1'b0;
            if (!busy_r) begin
                if (start) begin
                    shift_r <= {1'b1, data};
                    bit_r   <= 4'd0;
                    div_r   <= 32'd0;
                    busy_r  <= 1'b1;
                    tx_r    <= 1'b0;
                end
            end else if (div_r == 32'(CLK_DIV - 1)) begin
                div_r <= 32'd0;
                if (bit_r == 4'd9) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    tx_r   <= 1'b1;
                end else begin
                    tx_r    <= shift_r[0];
                    shift_r <= {1'b1, shift_r[8:1]};
                    bit_r   <= bit_r + 4'd1;
                end
            end else begin
                div_r <= div_r + 32'd1;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign tx   = tx_r;

endmodule

// File: rtl/isp_uart_host.sv
// ISP host: optionally syncs the target into debug mode, sends an ASCII
// command over UART and collects the fixed 8-byte reply into a response pulse.
module isp_uart_host
    import isp_uart_host_pkg::*;
#(
    parameter int UART_TX_CLK_DIV = 434,
    parameter int RSP_TIMEOUT     = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic [1:0]  o_rsp_status,
    output logic        o_uart_tx,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data
);

    state_e      state_r, state_s;
    op_e         op_r;
    logic [31:0] addr_r, data_r;
    logic        dbg_r, dbg_s;
    logic [4:0]  idx_r, idx_s;
    logic [63:0] rx_buf_r, rx_buf_s, rx_full_s;
    logic [3:0]  rx_cnt_r, rx_cnt_s;
    logic [31:0] wait_r, wait_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_data_r, rsp_data_s, read_val_s;
    status_e     rsp_status_r, rsp_status_s;
    logic        read_ok_s;
    logic        tx_start_s, tx_busy_s, tx_done_s;
    logic [7:0]  tx_byte_s;

    isp_host_byte_tx #(.CLK_DIV(UART_TX_CLK_DIV)) u_byte_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start_s),
        .data  (tx_byte_s),
        .busy  (tx_busy_s),
        .done  (tx_done_s),
        .tx    (o_uart_tx)
    );

    // next-state, byte sequencing, reply decoding and response formation
    always_comb begin
        state_s      = state_r;
        dbg_s        = dbg_r;
        idx_s        = idx_r;
        rx_buf_s     = rx_buf_r;
        rx_cnt_s     = rx_cnt_r;
        wait_s       = wait_r;
        rsp_valid_s  = 1'b0;
        rsp_data_s   = rsp_data_r;
        rsp_status_s = rsp_status_r;
        tx_start_s   = 1'b0;
        tx_byte_s    = (state_r == S_SYNC_TX) ? CH_LF : cmd_byte(op_r, addr_r, data_r, idx_r);
        rx_full_s    = {rx_buf_r[55:0], i_rx_data};
        read_ok_s    = 1'b1;
        read_val_s   = 32'h0;
        for (int k = 0; k < 8; k++) begin
            read_ok_s  = read_ok_s & is_hex(rx_full_s[63-8*k -: 8]);
            read_val_s = {read_val_s[27:0], hex_val(rx_full_s[63-8*k -: 8])};
        end

        case (state_r)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    state_s = dbg_r ? S_CMD_TX : S_SYNC_TX;
                    idx_s   = 5'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SYNC_TX, S_CMD_TX: begin
                if (!tx_done_s) begin
                    tx_start_s = !tx_busy_s;
                end else if (state_r == S_SYNC_TX) begin
                    state_s  = S_SYNC_RX;
                    rx_cnt_s = 4'd0;
                    wait_s   = 32'd0;
                end else if (idx_r == cmd_len(op_r) - 5'd1) begin
                    state_s  = S_RSP_RX;
                    rx_cnt_s = 4'd0;
                    wait_s   = 32'd0;
                end else begin
                    idx_s = idx_r + 5'd1;
                end
            end
            S_SYNC_RX, S_RSP_RX: begin
                // a byte landing on the timeout cycle wins and restarts the wait
                if (i_rx_valid) begin
                    rx_buf_s = rx_full_s;
                    rx_cnt_s = rx_cnt_r + 4'd1;
                    wait_s   = 32'd0;
                    if (rx_cnt_r != 4'd7) begin
                        state_s = state_r;
                    end else if (state_r == S_SYNC_RX && rx_full_s == STR_DEBUG) begin
                        dbg_s   = 1'b1;
                        state_s = S_CMD_TX;
                        idx_s   = 5'd0;
                    end else begin
                        state_s      = S_DONE;
                        rsp_valid_s  = 1'b1;
                        rsp_data_s   = 32'h0;
                        rsp_status_s = ST_INVALID;
                        if (state_r == S_RSP_RX) begin
                            case (op_r)
                                OP_READ: begin
                                    if (read_ok_s) begin
                                        rsp_data_s   = read_val_s;
                                        rsp_status_s = ST_OK;
                                    end else begin
                                        rsp_status_s = ST_INVALID;
                                    end
                                end
                                OP_WRITE: rsp_status_s = (rx_full_s == STR_WR_DONE) ? ST_OK : ST_INVALID;
                                OP_RESET: begin
                                    if (rx_full_s == STR_RST_DONE) begin
                                        rsp_status_s = ST_OK;
                                        dbg_s        = 1'b0;
                                    end else begin
                                        rsp_status_s = ST_INVALID;
                                    end
                                end
                                OP_OPEN: begin
                                    if (rx_full_s == STR_USER) begin
                                        rsp_status_s = ST_OK;
                                        dbg_s        = 1'b0;
                                    end else begin
                                        rsp_status_s = ST_INVALID;
                                    end
                                end
                                default: rsp_status_s = ST_INVALID;
                            endcase
                        end else begin
                            rsp_status_s = ST_INVALID;
                        end
                    end
                end else if (wait_r == 32'(RSP_TIMEOUT - 1)) begin
                    state_s      = S_DONE;
                    rsp_valid_s  = 1'b1;
                    rsp_data_s   = 32'h0;
                    rsp_status_s = ST_TIMEOUT;
                    dbg_s        = 1'b0;
                end else begin
                    wait_s = wait_r + 32'd1;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // state, command latch and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            op_r         <= OP_READ;
            addr_r       <= 32'h0;
            data_r       <= 32'h0;
            dbg_r        <= 1'b0;
            idx_r        <= 5'd0;
            rx_buf_r     <= 64'h0;
            rx_cnt_r     <= 4'd0;
            wait_r       <= 32'd0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= 32'h0;
            rsp_status_r <= ST_OK;
        end else begin
            state_r      <= state_s;
            dbg_r        <= dbg_s;
            idx_r        <= idx_s;
            rx_buf_r     <= rx_buf_s;
            rx_cnt_r     <= rx_cnt_s;
            wait_r       <= wait_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_data_r   <= rsp_data_s;
            rsp_status_r <= rsp_status_s;
            if (state_r == S_IDLE && i_cmd_valid) begin
                op_r   <= op_e'(i_cmd_op);
                addr_r <= i_cmd_addr;
                data_r <= i_cmd_data;
            end
        end
    end

    assign o_cmd_ready  = (state_r == S_IDLE) && !rst;
    assign o_rsp_valid  = rsp_valid_r;
    assign o_rsp_data   = rsp_data_r;
    assign o_rsp_status = rsp_status_r;

endmodule

// File: tb/tb_isp_uart_host.sv
// Bench for isp_uart_host: table of commands with target replies, a UART line
// decoder and a response scoreboard, plus timeout and mid-byte reset sequences.
module tb_isp_uart_host;

    localparam int DIV = 4;
    localparam int TMO = 200;
    localparam logic [63:0] DEBUG_STR = 64'h0d0a646562756720;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          sync;
        logic [63:0] sync_reply;
        logic [63:0] reply;
        int          stray;
        logic [31:0] exp_data;
        logic [1:0]  exp_status;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        uart_tx;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h0;

    int checks = 0;
    int failures = 0;
    int tx_count = 0;
    int rsp_seen = 0;
    logic [7:0] exp_tx_q[$];
    rsp_t       rsp_q[$];
    vec_t       rows[16];

    isp_uart_host #(.UART_TX_CLK_DIV(DIV), .RSP_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_data   (cmd_data),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_status (rsp_status),
        .o_uart_tx    (uart_tx),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART decoder: samples mid-bit on the falling edge and scores each byte
    initial begin
        int k;
        int j;
        logic [7:0] b;
        k = -1;
        b = 8'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                k = -1;
            end else if (k < 0) begin
                if (uart_tx == 1'b0) k = 0;
            end else begin
                k++;
                if (k % DIV == DIV / 2) begin
                    j = k / DIV;
                    if (j == 0) begin
                        check("tx_start_bit", uart_tx, 1'b0);
                    end else if (j <= 8) begin
                        b[j-1] = uart_tx;
                    end else begin
                        check("tx_stop_bit", uart_tx, 1'b1);
                        if (exp_tx_q.size() == 0) begin
                            check("tx_unexpected_byte", b, 64'hffff);
                        end else begin
                            check("tx_byte", b, exp_tx_q.pop_front());
                        end
                        tx_count++;
                        k = -1;
                    end
                end
            end
        end
    end

    // response scoreboard
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_seen++;
                check("ready_in_done", cmd_ready, 1'b0);
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'h1, 64'h0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_status", rsp_status, e.status);
                end
            end
        end
    end

    task automatic send_bytes(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = s[63-8*i -: 8];
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_tx(input int target);
        int t;
        t = 0;
        while (tx_count < target && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("tx_byte_count", tx_count, target);
        repeat (DIV + 4) @(negedge clk);
    endtask

    task automatic wait_rsp(input int target);
        int t;
        t = 0;
        while (rsp_seen < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rsp_count", rsp_seen, target);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    task automatic run_row(input vec_t v);
        string line;
        int    n0;
        int    r0;
        bit    sync_ok;
        rsp_t  e;
        n0 = tx_count;
        r0 = rsp_seen;
        sync_ok = !v.sync || (v.sync_reply == DEBUG_STR);
        line = v.sync ? "\n" : "";
        if (sync_ok) begin
            case (v.op)
                2'd0:    line = $sformatf("%s%08x\n", line, v.addr);
                2'd1:    line = $sformatf("%s%08x %08x\n", line, v.addr, v.data);
                2'd2:    line = $sformatf("%sr%08x\n", line, v.data);
                default: line = {line, "o\n"};
            endcase
        end
        for (int i = 0; i < line.len(); i++) exp_tx_q.push_back(line[i]);
        e.data   = v.exp_data;
        e.status = v.exp_status;
        rsp_q.push_back(e);
        if (v.stray == 1) send_bytes(64'h7800000000000000, 1);
        do_cmd(v.op, v.addr, v.data);
        if (v.stray == 2) send_bytes(64'h3000000000000000, 1);
        if (v.sync) begin
            wait_tx(n0 + 1);
            send_bytes(v.sync_reply, 8);
        end
        if (sync_ok) begin
            wait_tx(n0 + line.len());
            send_bytes(v.reply, 8);
        end
        wait_rsp(r0 + 1);
        repeat (3) @(negedge clk);
        check("rsp_data_hold", rsp_data, v.exp_data);
        check("rsp_status_hold", rsp_status, v.exp_status);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                                input bit s, input logic [63:0] sr, input logic [63:0] rp,
                                input int st, input logic [31:0] ed, input logic [1:0] es);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.sync = s; v.sync_reply = sr; v.reply = rp;
        v.stray = st; v.exp_data = ed; v.exp_status = es;
        return v;
    endfunction

    initial begin
        int   cyc;
        int   n0;
        int   r0;
        rsp_t e;
        rows[0]  = mk(2'd0, 32'h00000010, 32'h0, 1'b1, DEBUG_STR, "deadbeef", 0, 32'hdeadbeef, 2'd0);
        rows[1]  = mk(2'd1, 32'h20000004, 32'h12345678, 1'b0, 64'h0, "wr done ", 2, 32'h0, 2'd0);
        rows[2]  = mk(2'd2, 32'h0, 32'h00000100, 1'b0, 64'h0, "rst done", 0, 32'h0, 2'd0);
        rows[3]  = mk(2'd0, 32'habcdef01, 32'h0, 1'b1, DEBUG_STR, "0badf00d", 0, 32'h0badf00d, 2'd0);
        rows[4]  = mk(2'd0, 32'h0, 32'h0, 1'b0, 64'h0, "invalid ", 1, 32'h0, 2'd1);
        rows[5]  = mk(2'd1, 32'h1, 32'h2, 1'b0, 64'h0, "wr fail ", 0, 32'h0, 2'd1);
        rows[6]  = mk(2'd3, 32'h0, 32'h0, 1'b0, 64'h0, "user    ", 0, 32'h0, 2'd0);
        rows[7]  = mk(2'd0, 32'h0, 32'h0, 1'b1, DEBUG_STR, "DEADBEEF", 0, 32'h0, 2'd1);
        rows[8]  = mk(2'd0, 32'h40, 32'h0, 1'b0, 64'h0, "12345678", 0, 32'h12345678, 2'd0);
        rows[9]  = mk(2'd3, 32'h0, 32'h0, 1'b0, 64'h0, "user    ", 0, 32'h0, 2'd0);
        rows[10] = mk(2'd0, 32'h5, 32'h0, 1'b1, "\r\nDEBUG ", 64'h0, 0, 32'h0, 2'd1);
        rows[11] = mk(2'd0, 32'hffffffff, 32'h0, 1'b1, DEBUG_STR, "ffffffff", 0, 32'hffffffff, 2'd0);
        rows[12] = mk(2'd2, 32'h0, 32'hfedcba98, 1'b0, 64'h0, "rst fail", 0, 32'h0, 2'd1);
        rows[13] = mk(2'd0, 32'h80, 32'h0, 1'b1, DEBUG_STR, "00000001", 0, 32'h00000001, 2'd0);
        rows[14] = mk(2'd0, 32'h7, 32'h0, 1'b1, DEBUG_STR, "cafef00d", 0, 32'hcafef00d, 2'd0);

        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_status", rsp_status, 2'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1'b1);

        for (int i = 0; i < 13; i++) run_row(rows[i]);

        // timeout: only three reply bytes; pulse exactly TMO cycles after the third
        n0 = tx_count;
        r0 = rsp_seen;
        for (int i = 0; i < 9; i++) exp_tx_q.push_back(i < 8 ? 8'h30 + ((i == 6) ? 8'd4 : 8'd0) : 8'h0a);
        e.data = 32'h0;
        e.status = 2'd2;
        rsp_q.push_back(e);
        do_cmd(2'd0, 32'h00000040, 32'h0);
        wait_tx(n0 + 9);
        send_bytes(64'h6162630000000000, 3);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!rsp_valid && cyc < TMO + 100);
        check("timeout_latency", cyc, TMO);
        wait_rsp(r0 + 1);
        run_row(rows[13]);

        // reset during the start bit of a command byte
        do_cmd(2'd1, 32'h11112222, 32'h33334444);
        cyc = 0;
        while (uart_tx && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("line_low_before_rst", uart_tx, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midbyte_rst_uart_tx", uart_tx, 1'b1);
        check("midbyte_rst_ready", cmd_ready, 1'b0);
        check("midbyte_rst_valid", rsp_valid, 1'b0);
        check("midbyte_rst_data", rsp_data, 32'h0);
        check("midbyte_rst_status", rsp_status, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_tx_q.delete();
        #1;
        check("ready_after_midbyte_rst", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        check("ready_next_cycle", cmd_ready, 1'b1);
        run_row(rows[14]);

        repeat (20) @(negedge clk);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
